// File: rtl/lfsr_decrypt_pkg.sv
// Shared types and helpers for the LFSR stream decryptor.
//   state_t      : controller states
//   DEF_TAP_TBL  : default 6-bit candidate tap table, candidate 0 in the low bits
//   lfsr_next()  : one Fibonacci step, next = {s[lw-2:0], ^(s & taps)}, evaluated
//                  on a 32-bit carrier so one function serves any width lw < 32
package lfsr_dec_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_SEED, S_TRIAL, S_SELECT, S_DECRYPT, S_FILL, S_DONE
  } state_t;

  localparam logic [35:0] DEF_TAP_TBL = {6'h39, 6'h36, 6'h33, 6'h30, 6'h2D, 6'h21};

  function automatic logic [31:0] lfsr_next(input logic [31:0] s, input logic [31:0] taps,
                                            input int unsigned lw);
    logic [31:0] mask;
    mask = (32'd1 << lw) - 32'd1;
    return ((s << 1) | {31'd0, ^(s & taps & mask)}) & mask;
  endfunction
endpackage

// File: rtl/lfsr_decrypt_if.sv
// Memory port between the decryptor and the shared data memory.
//   raddr/rdata : combinational read (rdata valid in the same cycle)
//   wen/waddr/wdata : write, committed by the memory on the clock edge
// master = decryptor, slave = memory.
interface lfsr_decrypt_if #(parameter int AW = 8, parameter int DW = 8);
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  modport master(output raddr, wen, waddr, wdata, input rdata);
  modport slave (input raddr, wen, waddr, wdata, output rdata);
endinterface

// File: rtl/lfsr_step.sv
// Single LFSR register: load has priority over step.
//   clk, init (async active-high clear), load (take seed), en (step once),
//   seed, taps, state (current register value)
module lfsr_step import lfsr_dec_pkg::*; #(
  parameter int LW = 6
) (
  input  logic          clk,
  input  logic          init,
  input  logic          load,
  input  logic          en,
  input  logic [LW-1:0] seed,
  input  logic [LW-1:0] taps,
  output logic [LW-1:0] state
);
  logic [LW-1:0] r_state;

  always_ff @(posedge clk or posedge init) begin
    if (init)      r_state <= '0;
    else if (load) r_state <= seed;
    else if (en)   r_state <= LW'(lfsr_next(32'(r_state), 32'(taps), LW));
  end

  assign state = r_state;
endmodule

// File: rtl/lfsr_decrypt.sv
// LFSR stream decryptor. Recovers seed and tap pattern from a known pad
// preamble, then decrypts MSG_LEN bytes from ENC_BASE into OUT_BASE.
// Build option LFSR_DECRYPT_STRIP_EN: when defined, the leading pad run is
// dropped (count reported on km) and the tail refilled with PAD; when
// undefined every byte is written in place and km stays 0.
// Ports:
//   clk, init      : clock, async active-high reset (run starts after release)
//   tap_tbl        : NTAP candidate taps, candidate j at [j*LW +: LW]
//   mem            : memory port (master side)
//   done, err      : run complete / no candidate survived
//   tap_sel, km    : chosen candidate, leading pad bytes stripped
module lfsr_decrypt import lfsr_dec_pkg::*; #(
  parameter int            LW       = 6,
  parameter int            NTAP     = 6,
  parameter int            DW       = 8,
  parameter int            AW       = 8,
  parameter int            MSG_LEN  = 64,
  parameter int            ENC_BASE = 64,
  parameter int            OUT_BASE = 0,
  parameter int            PRE_LEN  = 7,
  parameter logic [DW-1:0] PAD      = DW'(8'h5F),
  localparam int           TSW      = (NTAP > 1) ? $clog2(NTAP) : 1
) (
  input  logic               clk,
  input  logic               init,
  input  logic [NTAP*LW-1:0] tap_tbl,
  lfsr_decrypt_if.master     mem,
  output logic               done,
  output logic               err,
  output logic [TSW-1:0]     tap_sel,
  output logic [AW-1:0]      km
);
  localparam logic [LW-1:0] PAD_LO = PAD[LW-1:0];

  state_t                   r_state;
  logic [AW-1:0]            r_cnt;     // trial index, byte index or fill index
  logic [LW-1:0]            r_seed;
  logic [NTAP-1:0]          r_alive;
  logic                     r_run;     // leading pad run still unbroken

  logic [NTAP-1:0][LW-1:0]  w_cand;
  logic [NTAP-1:0]          w_ok;
  logic [LW-1:0]            w_key;
  logic [LW-1:0]            w_rd_lo;
  logic [DW-1:0]            w_plain;
  logic                     w_strip;
  logic [AW-1:0]            w_km_nxt;
  logic [TSW-1:0]           w_pick;
  logic                     w_any;
  logic [LW-1:0]            w_wtaps;

  // Key bits implied by the preamble byte currently on the read port.
  assign w_rd_lo  = mem.rdata[LW-1:0] ^ PAD_LO;
  assign w_plain  = mem.rdata ^ DW'(w_key);
  assign w_wtaps  = tap_tbl[tap_sel*LW +: LW];
  assign w_km_nxt = km + AW'(w_strip);

`ifdef LFSR_DECRYPT_STRIP_EN
  assign w_strip = r_run && (w_plain == PAD) && (km < AW'(MSG_LEN));
`else
  assign w_strip = 1'b0;
`endif

  // Trial LFSRs: all load the seed together, then step through the preamble.
  for (genvar j = 0; j < NTAP; j++) begin : g_cand
    lfsr_step #(.LW(LW)) u_cand (
      .clk  (clk),
      .init (init),
      .load (r_state == S_SEED),
      .en   (r_state == S_TRIAL),
      .seed (w_rd_lo),
      .taps (tap_tbl[j*LW +: LW]),
      .state(w_cand[j])
    );
    assign w_ok[j] = LW'(lfsr_next(32'(w_cand[j]), 32'(tap_tbl[j*LW +: LW]), LW)) == w_rd_lo;
  end

  // Working LFSR restarts from the seed in SELECT and runs with the winner's taps.
  lfsr_step #(.LW(LW)) u_work (
    .clk  (clk),
    .init (init),
    .load (r_state == S_SELECT),
    .en   (r_state == S_DECRYPT),
    .seed (r_seed),
    .taps (w_wtaps),
    .state(w_key)
  );

  // Lowest index wins: scan downward so the last hit is the smallest.
  always_comb begin
    w_pick = '0;
    w_any  = 1'b0;
    for (int j = NTAP - 1; j >= 0; j--) begin
      if (r_alive[j]) begin
        w_pick = TSW'(j);
        w_any  = 1'b1;
      end
    end
  end

  always_comb begin
    mem.raddr = '0;
    mem.wen   = 1'b0;
    mem.waddr = '0;
    mem.wdata = '0;
    case (r_state)
      S_SEED:  mem.raddr = AW'(ENC_BASE);
      S_TRIAL: mem.raddr = AW'(ENC_BASE) + r_cnt;
      S_DECRYPT: begin
        mem.raddr = AW'(ENC_BASE) + r_cnt;
        mem.wen   = !w_strip;
        mem.waddr = AW'(OUT_BASE) + r_cnt - km;
        mem.wdata = w_plain;
      end
      S_FILL: begin
        mem.wen   = 1'b1;
        mem.waddr = AW'(OUT_BASE) + AW'(MSG_LEN) - km + r_cnt;
        mem.wdata = PAD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_seed  <= '0;
      r_alive <= '0;
      r_run   <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      tap_sel <= '0;
      km      <= '0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_SEED;
        S_SEED: begin
          r_seed  <= w_rd_lo;
          r_alive <= '1;
          r_cnt   <= AW'(1);
          r_state <= S_TRIAL;
        end
        S_TRIAL: begin
          r_alive <= r_alive & w_ok;
          if (r_cnt == AW'(PRE_LEN - 1)) r_state <= S_SELECT;
          else                           r_cnt   <= r_cnt + 1'b1;
        end
        S_SELECT: begin
          r_cnt <= '0;
          r_run <= 1'b1;
          if (w_any) begin
            tap_sel <= w_pick;
            r_state <= S_DECRYPT;
          end else begin
            err     <= 1'b1;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DECRYPT: begin
          km    <= w_km_nxt;
          r_run <= w_strip;
          if (r_cnt == AW'(MSG_LEN - 1)) begin
            r_cnt <= '0;
            if (w_km_nxt != '0) r_state <= S_FILL;
            else begin
              done    <= 1'b1;
              r_state <= S_DONE;
            end
          end else r_cnt <= r_cnt + 1'b1;
        end
        S_FILL: begin
          if (r_cnt == km - AW'(1)) begin
            done    <= 1'b1;
            r_state <= S_DONE;
          end else r_cnt <= r_cnt + 1'b1;
        end
        S_DONE:  ;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lfsr_decrypt.sv
// Bench for lfsr_decrypt: a 6-bit default instance and a 7-bit/2-candidate
// instance share one encrypted memory image. Expected writes come from a
// behavioural model and are matched by a monitor as the DUT issues them.
module tb_lfsr_decrypt;
  import lfsr_dec_pkg::*;

  localparam int         MSG_LEN  = 64;
  localparam int         ENC_BASE = 64;
  localparam int         OUT_BASE = 0;
  localparam int         PRE_LEN  = 7;
  localparam logic [7:0] PAD      = 8'h5F;

  typedef struct packed {logic [7:0] a; logic [7:0] d;} wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        init = 1'b1, init7 = 1'b1;
  logic        done, err, done7, err7;
  logic [2:0]  tap_sel;
  logic        tap_sel7;
  logic [7:0]  km, km7;
  logic [35:0] tbl6 = DEF_TAP_TBL;
  logic [13:0] tbl7 = {7'h60, 7'h41};

  logic [7:0] enc_mem [256];
  logic [7:0] out_mem [256];
  logic [7:0] out7    [256];

  lfsr_decrypt_if #(.AW(8), .DW(8)) mif ();
  lfsr_decrypt_if #(.AW(8), .DW(8)) mif7 ();
  assign mif.rdata  = enc_mem[mif.raddr];
  assign mif7.rdata = enc_mem[mif7.raddr];

  lfsr_decrypt #(.LW(6), .NTAP(6), .DW(8), .AW(8), .MSG_LEN(MSG_LEN), .ENC_BASE(ENC_BASE),
                 .OUT_BASE(OUT_BASE), .PRE_LEN(PRE_LEN), .PAD(PAD)) dut (
    .clk(clk), .init(init), .tap_tbl(tbl6), .mem(mif),
    .done(done), .err(err), .tap_sel(tap_sel), .km(km));

  lfsr_decrypt #(.LW(7), .NTAP(2), .DW(8), .AW(8), .MSG_LEN(MSG_LEN), .ENC_BASE(ENC_BASE),
                 .OUT_BASE(OUT_BASE), .PRE_LEN(PRE_LEN), .PAD(PAD)) dut7 (
    .clk(clk), .init(init7), .tap_tbl(tbl7), .mem(mif7),
    .done(done7), .err(err7), .tap_sel(tap_sel7), .km(km7));

  wr_t        wq[$], wq7[$], mq[$];
  logic [7:0] plain   [MSG_LEN];
  logic [7:0] exp_out [MSG_LEN];
  logic [7:0] c6 [8], c7 [8];
  int         exp_sel, exp_km, exp_done;
  bit         exp_err, strip_en;
  int         errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Key state after n steps, from the step rule: shift left, feed back tap parity.
  function automatic logic [7:0] st(input logic [7:0] s0, input logic [7:0] t, input int lw,
                                    input int n);
    logic [7:0] s = s0;
    int m = 1 << lw;
    for (int k = 0; k < n; k++) s = 8'(((s * 2) % m) + ($countones(s & t) % 2));
    return s;
  endfunction

  task automatic set_plain(input int npad, input string msg);
    foreach (plain[i]) plain[i] = PAD;
    for (int i = 0; i < msg.len(); i++) plain[npad + i] = msg[i];
  endtask

  task automatic encrypt(input logic [7:0] seed, input logic [7:0] t, input int lw);
    for (int i = 0; i < MSG_LEN; i++) enc_mem[ENC_BASE + i] = plain[i] ^ st(seed, t, lw, i);
  endtask

  // Reference: recover the seed from byte 0, keep candidates whose key stream
  // turns the preamble into pad, decrypt with the first survivor.
  task automatic model(input int lw, input int ntap, input logic [7:0] cand [8]);
    int m = 1 << lw;
    logic [7:0] s0, p;
    bit ok, run;
    s0 = 8'((enc_mem[ENC_BASE] ^ PAD) % m);
    exp_err = 1'b1; exp_sel = 0; exp_km = 0;
    for (int j = 0; j < ntap; j++) begin
      ok = 1'b1;
      for (int k = 0; k < PRE_LEN; k++)
        if (8'((enc_mem[ENC_BASE + k] ^ PAD) % m) != st(s0, cand[j], lw, k)) ok = 1'b0;
      if (ok && exp_err) begin exp_err = 1'b0; exp_sel = j; end
    end
    mq.delete();
    foreach (exp_out[i]) exp_out[i] = 8'h00;
    if (exp_err) begin exp_done = PRE_LEN + 2; return; end
    run = strip_en;
    for (int i = 0; i < MSG_LEN; i++) begin
      p = enc_mem[ENC_BASE + i] ^ st(s0, cand[exp_sel], lw, i);
      if (run && p == PAD) exp_km++;
      else begin
        run = 1'b0;
        mq.push_back('{a: 8'(OUT_BASE + i - exp_km), d: p});
        exp_out[i - exp_km] = p;
      end
    end
    for (int f = 0; f < exp_km; f++) begin
      mq.push_back('{a: 8'(OUT_BASE + MSG_LEN - exp_km + f), d: PAD});
      exp_out[MSG_LEN - exp_km + f] = PAD;
    end
    exp_done = PRE_LEN + MSG_LEN + 2 + exp_km;
  endtask

  task automatic prep(input bit w);
    init = 1'b1; init7 = 1'b1;
    foreach (out_mem[i]) begin out_mem[i] = 8'h00; out7[i] = 8'h00; end
    if (w) wq7 = mq; else wq = mq;
    @(negedge clk);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_done"}, 32'(done), 0);   chk({nm, "_err"}, 32'(err), 0);
    chk({nm, "_tsel"}, 32'(tap_sel), 0); chk({nm, "_km"}, 32'(km), 0);
    chk({nm, "_wen"}, 32'(mif.wen), 0);  chk({nm, "_raddr"}, 32'(mif.raddr), 0);
    chk({nm, "_waddr"}, 32'(mif.waddr), 0); chk({nm, "_wdata"}, 32'(mif.wdata), 0);
  endtask

  // Release reset before the next edge (edge 0); cycle n is the one after edge n-1.
  task automatic run(input bit w, input int abort_at, input string nm);
    int cyc = 0;
    int bad = 0;
    if (w) init7 = 1'b0; else init = 1'b0;
    forever begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (cyc == abort_at) begin
        #2 init = 1'b1;
        #1 chk_idle({nm, "_abort"});
        wq.delete();
        return;
      end
      if (w ? done7 : done) break;
      if (cyc > 400) begin
        checks++; errors++;
        $display("FAIL %s_timeout: no done after %0d cycles, expected at %0d", nm, cyc, exp_done);
        break;
      end
    end
    chk({nm, "_done_cyc"}, 32'(cyc), 32'(exp_done));
    chk({nm, "_err"}, 32'(w ? err7 : err), 32'(exp_err));
    chk({nm, "_tap_sel"}, w ? 32'(tap_sel7) : 32'(tap_sel), 32'(exp_sel));
    chk({nm, "_km"}, 32'(w ? km7 : km), 32'(exp_km));
    chk({nm, "_wen_done"}, 32'(w ? mif7.wen : mif.wen), 0);
    chk({nm, "_writes_left"}, 32'(w ? wq7.size() : wq.size()), 0);
    for (int i = 0; i < MSG_LEN; i++)
      if ((w ? out7[OUT_BASE + i] : out_mem[OUT_BASE + i]) !== exp_out[i]) bad++;
    chk({nm, "_out_bad_bytes"}, 32'(bad), 0);
    if (w) init7 = 1'b1; else init = 1'b1;
  endtask

  initial begin
    fork
      begin : monitor
        wr_t e;
        forever begin
          @(negedge clk);
          if (mif.wen === 1'b1) begin
            if (wq.size() == 0) begin
              checks++; errors++;
              $display("FAIL write_extra: addr %0h data %0h, no write expected", mif.waddr, mif.wdata);
            end else begin
              e = wq.pop_front();
              chk("waddr", 32'(mif.waddr), 32'(e.a));
              chk("wdata", 32'(mif.wdata), 32'(e.d));
            end
            out_mem[mif.waddr] = mif.wdata;
          end
          if (mif7.wen === 1'b1) begin
            if (wq7.size() == 0) begin
              checks++; errors++;
              $display("FAIL write7_extra: addr %0h data %0h, no write expected", mif7.waddr, mif7.wdata);
            end else begin
              e = wq7.pop_front();
              chk("waddr7", 32'(mif7.waddr), 32'(e.a));
              chk("wdata7", 32'(mif7.wdata), 32'(e.d));
            end
            out7[mif7.waddr] = mif7.wdata;
          end
        end
      end
    join_none

`ifdef LFSR_DECRYPT_STRIP_EN
    strip_en = 1'b1;
`else
    strip_en = 1'b0;
`endif
    foreach (c6[j]) begin c6[j] = 8'h00; c7[j] = 8'h00; end
    for (int j = 0; j < 6; j++) c6[j] = 8'(tbl6[j*6 +: 6]);
    c7[0] = 8'h41; c7[1] = 8'h60;
    foreach (enc_mem[i]) enc_mem[i] = 8'h00;

    repeat (3) @(negedge clk);
    chk_idle("reset");

    // Known-plaintext message behind a 10-byte pad run
    set_plain(10, "HELLO"); encrypt(8'h0B, 8'h2D, 6); model(6, 6, c6);
    prep(0); run(0, 0, "hello");

    // Noise: no candidate should explain the preamble
    for (int i = 0; i < MSG_LEN; i++) enc_mem[ENC_BASE + i] = 8'($urandom);
    model(6, 6, c6); prep(0); run(0, 0, "noise");

    // Embedded pad must survive, only the leading run goes
    set_plain(7, "A_B");
    encrypt(8'($urandom_range(1, 63)), c6[$urandom_range(0, 5)], 6);
    model(6, 6, c6); prep(0); run(0, 0, "a_b");

    // Abort mid-DECRYPT, then a clean rerun of the first scenario
    set_plain(10, "HELLO"); encrypt(8'h0B, 8'h2D, 6); model(6, 6, c6);
    prep(0); run(0, 30, "mid");
    prep(0); run(0, 0, "rerun");

    // All pad: saturating strip count, fill covers the whole region
    set_plain(0, "");
    encrypt(8'($urandom_range(1, 63)), c6[$urandom_range(0, 5)], 6);
    model(6, 6, c6); prep(0); run(0, 0, "allpad");

    // Random pad lengths and random payloads
    for (int r = 0; r < 3; r++) begin
      int np = $urandom_range(PRE_LEN, 20);
      set_plain(np, "");
      for (int i = np; i < MSG_LEN; i++) plain[i] = 8'($urandom);
      encrypt(8'($urandom_range(1, 63)), c6[$urandom_range(0, 5)], 6);
      model(6, 6, c6); prep(0); run(0, 0, "rand");
    end

    // 7-bit instance, message keyed with the second candidate
    set_plain(9, "Lw7");
    for (int i = 12; i < MSG_LEN; i++) plain[i] = 8'($urandom);
    encrypt(8'($urandom_range(1, 127)), 8'h60, 7);
    model(7, 2, c7); prep(1); run(1, 0, "lw7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lfsr_decrypt.md
# lfsr_decrypt

Parametrised LFSR stream decryptor: it recovers the unknown tap pattern and seed from a known-plaintext preamble of pad characters, then decrypts a message held in data memory. It writes the message back with the leading pad run stripped and the tail refilled. It replaces the fixed-timing, 6-bit, cycle-count-driven decryptor with an explicit FSM, an external memory port and per-step candidate elimination. It sits between the shared data memory and the lab top level.

## Interface
- `LW`, 6 — LFSR width; key bits XOR the low `LW` bits of each byte.
- `NTAP`, 6 — number of candidate tap patterns.
- `DW`, 8 — memory data width.
- `AW`, 8 — memory address width.
- `MSG_LEN`, 64 — message length in bytes.
- `ENC_BASE`, 64 — address of encrypted byte 0.
- `OUT_BASE`, 0 — address of decrypted byte 0.
- `PRE_LEN`, 7 — preamble bytes used for tap discovery (≥2).
- `PAD`, 8'h5F — pad character.
- `clk  in  1` — clock.
- `init  in  1` — asynchronous, active-high reset; a run starts on the first rising edge after deassertion.
- `tap_tbl  in  NTAP*LW` — candidate taps; candidate j is bits `[j*LW +: LW]`.
- `raddr  out  AW` — memory read address; read is combinational (`rdata` valid in the same cycle).
- `rdata  in  DW` — memory read data.
- `wen  out  1` — memory write enable.
- `waddr  out  AW` — memory write address.
- `wdata  out  DW` — memory write data.
- `done  out  1` — run complete; held until `init`.
- `err  out  1` — no candidate survived discovery.
- `tap_sel  out  $clog2(NTAP)` — index of the chosen candidate.
- `km  out  AW` — number of leading pad bytes stripped.

## Operation
- LFSR step: `next = {s[LW-2:0], ^(s & taps)}`.
- Encryption model: `enc[i] = plain[i] ^ {0, s_i}`, where `s_0` is the seed and `s_{i+1} = step(s_i)`.
- Candidate j is consistent when `plain[k] == PAD` for all `k < PRE_LEN`.
- FSM states: IDLE, SEED, TRIAL, SELECT, DECRYPT, FILL, DONE.
- IDLE: entered on reset; advances to SEED on the first clock after `init` deasserts.
- SEED: `raddr=ENC_BASE`. Every candidate register loads `rdata[LW-1:0]^PAD[LW-1:0]`; all `NTAP` alive bits are set.
- TRIAL, k=1..PRE_LEN-1: `raddr=ENC_BASE+k`. Each candidate steps once. Its alive bit clears if `step(s) != rdata[LW-1:0]^PAD[LW-1:0]`.
- SELECT: picks the lowest-index alive candidate. It reloads the working LFSR with the seed and latches `tap_sel`.
  - If no candidate is alive: `err=1` and the FSM goes to DONE with no writes.
- DECRYPT, i=0..MSG_LEN-1, one byte per cycle:
  - Read `ENC_BASE+i`; `p = rdata ^ {0,s}`; the working LFSR then steps.
  - While the leading run is unbroken and `p==PAD`: `km++` and no write.
  - Otherwise the run is broken permanently and the block writes `p` to `OUT_BASE+i-km`.
- FILL: writes `PAD` to `OUT_BASE+MSG_LEN-km .. OUT_BASE+MSG_LEN-1`, one per cycle. It is skipped when `km==0`.
- DONE: `done=1`, no memory activity. The FSM stays here until `init`.
- Width rules:
  - Upper `DW-LW` bits pass through XOR unchanged.
  - Address arithmetic is modulo `2^AW`.
  - `km` saturates at `MSG_LEN`.

## Timing
- Reset values: `done=0`, `err=0`, `tap_sel=0`, `km=0`, `wen=0`, `raddr=0`, `waddr=0`, `wdata=0`. The reset is asynchronous.
- `wen`, `waddr` and `wdata` are decoded combinationally from state and counters. They are never asserted in IDLE, SEED, TRIAL, SELECT or DONE.
- Latency with `init` deasserting before edge 0:
  - SEED at cycle 1.
  - TRIAL at cycles 2..PRE_LEN.
  - SELECT at cycle PRE_LEN+1.
  - DECRYPT for MSG_LEN cycles.
  - FILL for km cycles.
  - `done` rises at cycle `PRE_LEN+MSG_LEN+km+2`. With defaults that is `73+km`.
- With `err`: `done` rises at cycle `PRE_LEN+2`.
- Multiple survivors: lowest index wins; no flag is raised.
- All-pad message: `km=MSG_LEN`, no DECRYPT writes, and FILL rewrites the whole region.
- `init` asserted mid-run: the FSM immediately returns to IDLE with all outputs at reset values. Partially written memory is left as is.

## Configuration
- `LFSR_DECRYPT_STRIP_EN`:
  - Defined: leading-pad stripping and FILL as above.
  - Undefined: every decrypted byte is written to `OUT_BASE+i`, `km` is tied to 0, FILL is never entered, and `done` rises at `PRE_LEN+MSG_LEN+2`.

## Structure
- Package `lfsr_dec_pkg` holds:
  - the state enum;
  - the default 6-bit tap table constant (6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39);
  - the `lfsr_next(state, taps)` function.
- Sub-module `lfsr_step`, parametrised by `LW`, with ports `clk, init, load, en, seed, taps, state`. It is instantiated `NTAP` times for trials plus once for the working LFSR.

## Test plan
- Default parameters, taps 6'h2D, seed 6'h0B, plaintext of 10 PAD bytes followed by "HELLO", rest PAD → `tap_sel=1`, `km=10`, OUT[0..4]="HELLO", OUT[54..63]=8'h5F, `done` at cycle 83.
- Encrypted buffer of random bytes matching no candidate → `err=1`, `done` at cycle 9, zero writes observed.
- Plaintext PAD×7, then "A_B", rest PAD → only the leading run is stripped, the embedded `_` is kept: OUT[0..2]="A_B", `km=7`.
- Assert `init` during DECRYPT at cycle 30 → all outputs 0 next cycle. After release, a full rerun yields results identical to the first scenario.
- Build with `LFSR_DECRYPT_STRIP_EN` undefined, first-scenario stimulus → OUT[0..9]=PAD, OUT[10..14]="HELLO", `km=0`, `done` at cycle 73.
- `LW=7`, `NTAP=2`, taps {7'h41, 7'h60}, message built with 7'h60 → `tap_sel=1` and a correct decrypt.
